// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings, responder FSM states and the store byte-enable helper.
// No ports; imported by dmem_responder and dmem_load_align.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dmem_state_t;

   // Byte lanes touched by a store; lane 0 is bits [7:0] (little-endian).
   // Load-only or illegal encodings return no lanes.
   function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic [3:0] be;
      case (funct3)
         F3_B:    be = 4'b0001 << addr_lo;
         F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the byte/halfword addressed by addr_i out of a RAM
// word and sign- or zero-extends it according to the RV32I load funct3.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: word_i (RAM word), addr_i (byte offset), funct3_i, data_o (result;
// 0 for non-load encodings).
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[8*addr_i +: 8];
      // Halfword offset uses only addr_i[1]; an odd address is flagged as
      // misaligned by the caller, which discards this result.
      half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    data_o = word_i;
         F3_BU:   data_o = {24'd0, byte_sel};
         F3_HU:   data_o = {16'd0, half_sel};
         default: data_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores and RV32I load extraction.
// Latency: response valid LATENCY cycles after request accept; one access in flight.
// Backpressure: req_ready low outside IDLE; response held stable until rsp_ready.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_we/req_addr/
// req_funct3/req_wdata request side; rsp_valid/rsp_ready/rsp_rdata/rsp_err
// response side.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         DEPTH  = 2**ADDR_W;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   // Misaligned halfword/word, or a funct3 that is not a legal load/store.
   function automatic logic access_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
      logic e;
      case (funct3)
         F3_B:    e = 1'b0;
         F3_H:    e = addr_lo[0];
         F3_W:    e = (addr_lo != 2'b00);
         F3_BU:   e = we;
         F3_HU:   e = we | addr_lo[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   logic [31:0] mem_q [DEPTH];

   dmem_state_t         state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;

   // Request fields captured at accept; only the word index and byte offset
   // of the address matter, so addresses wrap modulo DEPTH*4.
   logic                we_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [2:0]          f3_q;
   logic [31:0]         wdata_q;

   logic                unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   logic [ADDR_W-1:0]   word_idx;
   logic [31:0]         rd_word;
   logic [31:0]         ld_data;
   logic                acc_err;
   logic                commit;
   logic [3:0]          be;
   logic [31:0]         st_data;

   assign word_idx = addr_q[ADDR_W+1:2];
   assign rd_word  = mem_q[word_idx];
   assign acc_err  = access_err(we_q, f3_q, addr_q[1:0]);
   assign commit   = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign be       = byte_en(f3_q, addr_q[1:0]);

   // Replicate store data across lanes; byte enables choose which copy lands.
   always_comb begin
      case (f3_q)
         F3_B:    st_data = {4{wdata_q[7:0]}};
         F3_H:    st_data = {2{wdata_q[15:0]}};
         default: st_data = wdata_q;
      endcase
   end

   dmem_load_align u_load_align (
      .word_i   (rd_word),
      .addr_i   (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (ld_data)
   );

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = ACCESS;
               cnt_d   = LAT_M1;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               rdata_d = (we_q || acc_err) ? 32'd0 : ld_data;
               err_d   = acc_err;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (req_ready && req_valid) begin
         we_q    <= req_we;
         addr_q  <= req_addr[ADDR_W+1:0];
         f3_q    <= req_funct3;
         wdata_q <= req_wdata;
      end
   end

   // Reset wins over a commit in the same cycle, so an interrupted store
   // never reaches the RAM.
   always_ff @(posedge clk) begin
      if (!reset && commit && we_q && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: LATENCY=1, instance b: LATENCY=4
   logic        a_reset, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic [2:0]  a_req_funct3;
   logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [2:0]  b_req_funct3;

   dmem_responder #(.ADDR_W(12), .LATENCY(1)) dut_a (
      .clk(clk), .reset(a_reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_funct3(a_req_funct3), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   dmem_responder #(.ADDR_W(12), .LATENCY(4)) dut_b (
      .clk(clk), .reset(b_reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_funct3(b_req_funct3), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   int   n_chk = 0;
   int   n_err = 0;
   rsp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic rd_req_ready(input bit sel);
      return sel ? b_req_ready : a_req_ready;
   endfunction
   function automatic logic rd_valid(input bit sel);
      return sel ? b_rsp_valid : a_rsp_valid;
   endfunction
   function automatic logic [31:0] rd_rdata(input bit sel);
      return sel ? b_rsp_rdata : a_rsp_rdata;
   endfunction
   function automatic logic rd_err(input bit sel);
      return sel ? b_rsp_err : a_rsp_err;
   endfunction

   task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd);
      if (sel) begin
         b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_funct3 = f3; b_req_wdata = wd;
      end else begin
         a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_funct3 = f3; a_req_wdata = wd;
      end
   endtask

   task automatic set_rsp_ready(input bit sel, input logic r);
      if (sel) b_rsp_ready = r;
      else     a_rsp_ready = r;
   endtask

   // One full transaction: accept, measure latency, compare against the
   // scoreboard, optionally stall, then hand the response back.
   task automatic issue(input bit sel, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                        input int lat, input int stall, input string tag);
      rsp_t e;
      int   cyc;
      check({tag, " req_ready before accept"}, 32'(rd_req_ready(sel)), 32'd1);
      drive(sel, 1'b1, we, addr, f3, wd);
      @(posedge clk); #1;
      // Scramble non-valid inputs: they are don't-care after the accept edge.
      drive(sel, 1'b0, 1'($urandom), $urandom, 3'($urandom), $urandom);
      sb.push_back('{d: exp_d, e: exp_e});
      cyc = 0;
      while (!rd_valid(sel) && cyc < 40) begin
         check({tag, " req_ready busy"}, 32'(rd_req_ready(sel)), 32'd0);
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      e = sb.pop_front();
      check({tag, " rdata"}, rd_rdata(sel), e.d);
      check({tag, " err"}, 32'(rd_err(sel)), 32'(e.e));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check({tag, " stall valid"}, 32'(rd_valid(sel)), 32'd1);
         check({tag, " stall rdata"}, rd_rdata(sel), e.d);
         check({tag, " stall err"}, 32'(rd_err(sel)), 32'(e.e));
         check({tag, " stall req_ready"}, 32'(rd_req_ready(sel)), 32'd0);
      end
      set_rsp_ready(sel, 1'b1);
      @(posedge clk); #1;
      set_rsp_ready(sel, 1'b0);
      check({tag, " post valid"}, 32'(rd_valid(sel)), 32'd0);
      check({tag, " post req_ready"}, 32'(rd_req_ready(sel)), 32'd1);
      check({tag, " post rdata"}, rd_rdata(sel), 32'd0);
      check({tag, " post err"}, 32'(rd_err(sel)), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      a_reset = 1'b1; b_reset = 1'b1;
      a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      a_reset = 1'b0; b_reset = 1'b0;

      // Reset state
      check("reset a req_ready", 32'(a_req_ready), 32'd1);
      check("reset a rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("reset a rsp_rdata", a_rsp_rdata, 32'd0);
      check("reset a rsp_err",   32'(a_rsp_err), 32'd0);
      check("reset b req_ready", 32'(b_req_ready), 32'd1);
      check("reset b rsp_valid", 32'(b_rsp_valid), 32'd0);

      // LATENCY=1: word store/load and sub-word extraction
      issue(0, 1, 32'h10, F3_W,  32'hDEADBEEF, 32'h0,        0, 1, 0, "SW 10");
      issue(0, 0, 32'h10, F3_W,  32'h0,        32'hDEADBEEF, 0, 1, 0, "LW 10");
      issue(0, 0, 32'h13, F3_B,  32'h0,        32'hFFFFFFDE, 0, 1, 0, "LB 13");
      issue(0, 0, 32'h13, F3_BU, 32'h0,        32'h000000DE, 0, 1, 0, "LBU 13");
      issue(0, 0, 32'h10, F3_H,  32'h0,        32'hFFFFBEEF, 0, 1, 0, "LH 10");
      issue(0, 0, 32'h12, F3_HU, 32'h0,        32'h0000DEAD, 0, 1, 0, "LHU 12");
      issue(0, 0, 32'h11, F3_BU, 32'h0,        32'h000000BE, 0, 1, 0, "LBU 11");

      // Lane steering
      issue(0, 1, 32'h11, F3_B,  32'h000000AA, 32'h0,        0, 1, 0, "SB 11");
      issue(0, 0, 32'h10, F3_W,  32'h0,        32'hDEADAAEF, 0, 1, 0, "LW after SB");
      issue(0, 1, 32'h12, F3_H,  32'hFFFF1234, 32'h0,        0, 1, 0, "SH 12");
      issue(0, 0, 32'h10, F3_W,  32'h0,        32'h1234AAEF, 0, 1, 0, "LW after SH");
      // Upper address bits ignored: 0x4010 aliases 0x10 with 4K words
      issue(0, 0, 32'h4010, F3_W, 32'h0,       32'h1234AAEF, 0, 1, 0, "LW wrap");

      // Error cases
      issue(0, 1, 32'h20, F3_W,  32'hCAFEF00D, 32'h0,        0, 1, 0, "SW 20");
      issue(0, 1, 32'h22, F3_W,  32'h11111111, 32'h0,        1, 1, 0, "SW 22 misaligned");
      issue(0, 0, 32'h20, F3_W,  32'h0,        32'hCAFEF00D, 0, 1, 0, "LW 20 unchanged");
      issue(0, 0, 32'h21, F3_H,  32'h0,        32'h0,        1, 1, 0, "LH 21 misaligned");
      issue(0, 0, 32'h20, 3'b011, 32'h0,       32'h0,        1, 1, 0, "load f3 011");
      issue(0, 1, 32'h20, F3_BU, 32'h22222222, 32'h0,        1, 1, 0, "store f3 100");
      issue(0, 0, 32'h23, F3_HU, 32'h0,        32'h0,        1, 1, 0, "LHU 23 misaligned");
      issue(0, 0, 32'h20, F3_W,  32'h0,        32'hCAFEF00D, 0, 1, 0, "LW 20 after errs");

      // LATENCY=4 with a 5-cycle response stall
      issue(1, 1, 32'h40, F3_W,  32'h11223344, 32'h0,        0, 4, 5, "L4 SW 40");
      issue(1, 0, 32'h40, F3_W,  32'h0,        32'h11223344, 0, 4, 5, "L4 LW 40");
      issue(1, 0, 32'h42, F3_H,  32'h0,        32'h00001122, 0, 4, 0, "L4 LH 42");

      // Reset in the second ACCESS cycle of a store: store is dropped
      drive(1'b1, 1'b1, 1'b1, 32'h40, F3_W, 32'h55);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      @(posedge clk); #1;
      b_reset = 1'b1;
      @(posedge clk); #1;
      b_reset = 1'b0;
      check("mid-reset req_ready", 32'(b_req_ready), 32'd1);
      check("mid-reset rsp_valid", 32'(b_rsp_valid), 32'd0);
      check("mid-reset rsp_rdata", b_rsp_rdata, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("mid-reset no late rsp", 32'(b_rsp_valid), 32'd0);
      issue(1, 0, 32'h40, F3_W,  32'h0,        32'h11223344, 0, 4, 0, "L4 LW 40 after reset");

      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
